// File: rtl/booth_seq_if.sv
// booth_seq_if: bundles the request/result handshake and the booth datapath
// hookup of booth_seq.
//   start, a_in, b_in, signed_mode : request and operands (requester -> block)
//   busy, done, product            : status and captured result (block -> requester)
//   dp_multiplicand, dp_multiplier,
//   dp_count, dp_reset             : operands and step control (block -> datapath)
//   dp_result                      : running result (datapath -> block)
// Modport slave is the sequencer side; master is the requester/datapath side.
interface booth_seq_if #(
   parameter int N  = 4,
   parameter int PW = 2*N
);
   logic          start;
   logic [N-1:0]  a_in;
   logic [N-1:0]  b_in;
   logic          signed_mode;
   logic          busy;
   logic          done;
   logic [PW-1:0] product;
   logic [PW-1:0] dp_multiplicand;
   logic [N-1:0]  dp_multiplier;
   logic [2:0]    dp_count;
   logic          dp_reset;
   logic [PW-1:0] dp_result;

   modport slave (
      input  start, a_in, b_in, signed_mode, dp_result,
      output busy, done, product, dp_multiplicand, dp_multiplier, dp_count, dp_reset
   );

   modport master (
      output start, a_in, b_in, signed_mode, dp_result,
      input  busy, done, product, dp_multiplicand, dp_multiplier, dp_count, dp_reset
   );
endinterface

// File: rtl/booth_seq.sv
// booth_seq: control sequencer for an external radix-2 booth datapath.
// A start in IDLE latches the operands, LOAD clears the datapath for one
// cycle, RUN steps dp_count through 0..N-1, and the datapath result is
// captured into product on the edge leaving the last RUN cycle; DONE then
// pulses done for one cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : booth_seq_if.slave (request, status, product, datapath hookup)
module booth_seq #(
   parameter int N  = 4,
   parameter int PW = 2*N
) (
   input  logic        clk,
   input  logic        reset,
   booth_seq_if.slave  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [2:0] LAST = 3'(N-1);

   logic [1:0]    state;
   logic [2:0]    count;
   logic [N-1:0]  a_q;
   logic [N-1:0]  b_q;
   logic          sm_q;
   logic [PW-1:0] product_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sm_q      <= 1'b0;
         product_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q   <= bus.a_in;
                  b_q   <= bus.b_in;
                  sm_q  <= bus.signed_mode;
                  state <= LOAD;
               end
            end
            LOAD: begin
               count <= '0;
               state <= RUN;
            end
            RUN: begin
               // dp_result already includes the final step combinationally,
               // so capture happens on the edge that leaves the last step
               if (count == LAST) begin
                  product_q <= bus.dp_result;
                  count     <= '0;
                  state     <= DONE;
               end else begin
                  count <= count + 3'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy            = (state != IDLE);
      bus.done            = (state == DONE);
      bus.dp_reset        = (state == IDLE) || (state == LOAD);
      bus.dp_count        = count;
      bus.product         = product_q;
      bus.dp_multiplier   = b_q;
      // upper bits replicate the sign bit only in signed mode
      bus.dp_multiplicand = {{(PW-N){sm_q & a_q[N-1]}}, a_q};
   end
endmodule
